spi_tft_tx: RTL and testbench

SPI_TFT_TX -- requirements
Module: spi_tft_tx

---
 rtl/spi_tft_tx_if.sv | 35 +++
 rtl/spi_tft_tx.sv | 165 ++++++++++++++++
 tb/tb_spi_tft_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tft_tx_if.sv
// Byte-request and panel-pin bundle for the TFT SPI transmitter.
// The slave side is the transmitter; the master side is the panel
// controller, which also observes the panel lines.
interface spi_tft_tx_if;
    logic       send_en;
    logic       send_dc;
    logic [7:0] send_data;
    logic       send_busy;
    logic       tft_cs;
    logic       tft_sclk;
    logic       tft_mosi;
    logic       tft_dc;

    modport master (
        output send_en,
        output send_dc,
        output send_data,
        input  send_busy,
        input  tft_cs,
        input  tft_sclk,
        input  tft_mosi,
        input  tft_dc
    );

    modport slave (
        input  send_en,
        input  send_dc,
        input  send_data,
        output send_busy,
        output tft_cs,
        output tft_sclk,
        output tft_mosi,
        output tft_dc
    );
endinterface

// File: rtl/spi_tft_tx.sv
// Single-byte SPI mode-0 transmitter for a TFT panel with D/C line.
// One byte per request: chip select drops with the first data bit, eight
// SCLK pulses shift the byte out MSB first, chip select is held one more
// SCLK period after the last pulse, then stays high for a CS gap before
// the transmitter reports idle again.  Every panel pin is a flop output.
module spi_tft_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_tft_tx_if.slave bus
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] cnt_q,       cnt_d;
    logic [3:0] bitCnt_q,    bitCnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       holdPhase_q, holdPhase_d;
    logic       busy_q,      busy_d;
    logic       cs_q,        cs_d;
    logic       sclk_q,      sclk_d;
    logic       mosi_q,      mosi_d;
    logic       dc_q,        dc_d;

    // State, counters and all panel-facing outputs; reset returns to an idle, deselected bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            holdPhase_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            holdPhase_q <= holdPhase_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            dc_q        <= dc_d;
        end
    end

    // Sequencing: each phase lasts a reloaded count; HOLD covers the last SCLK low phase then the CS hold
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        holdPhase_d = holdPhase_q;
        busy_d      = busy_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        dc_d        = dc_q;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bitCnt_d = '0;
                if (bus.send_en) begin
                    state_d     = SETUP;
                    cnt_d       = DIV_LOAD;
                    shift_d     = {bus.send_data[6:0], 1'b0};
                    mosi_d      = bus.send_data[7];
                    dc_d        = bus.send_dc;
                    cs_d        = 1'b0;
                    busy_d      = 1'b1;
                    sclk_d      = 1'b0;
                    holdPhase_d = 1'b0;
                end
            end

            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d  = SHIFT;
                    cnt_d    = DIV_LOAD;
                    sclk_d   = 1'b1;
                    bitCnt_d = 4'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            SHIFT: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = DIV_LOAD;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bitCnt_q == 4'd8) begin
                            state_d     = HOLD;
                            holdPhase_d = 1'b0;
                        end else begin
                            mosi_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        sclk_d   = 1'b1;
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            HOLD: begin
                if (cnt_q == 8'd0) begin
                    if (!holdPhase_q) begin
                        holdPhase_d = 1'b1;
                        cnt_d       = DIV_LOAD;
                    end else begin
                        state_d     = GAP;
                        holdPhase_d = 1'b0;
                        cnt_d       = GAP_LOAD;
                        cs_d        = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    bitCnt_d = '0;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.send_busy = busy_q;
    assign bus.tft_cs    = cs_q;
    assign bus.tft_sclk  = sclk_q;
    assign bus.tft_mosi  = mosi_q;
    assign bus.tft_dc    = dc_q;

endmodule

// File: tb/tb_spi_tft_tx.sv
// Bench for spi_tft_tx: one instance at default timing, one at the fastest
// timing.  Stimulus pushes the expected byte description into a per-instance
// queue; a monitor decodes the panel pins and compares each byte as it ends.
module tb_spi_tft_tx;

    localparam int DIV0 = 2;
    localparam int GAP0 = 2;
    localparam int DIV1 = 1;
    localparam int GAP1 = 1;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         busyLen;
        int         csLowLen;
        int         gapBefore;
        int         csHighBefore;
        bit         aborted;
        int         abortRises;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_tft_tx_if bus0 ();
    spi_tft_tx_if bus1 ();

    spi_tft_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    spi_tft_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    // Free-running system clock
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q0[$];
    exp_t q1[$];

    wire [1:0] busyV = {bus1.send_busy, bus0.send_busy};
    wire [1:0] csV   = {bus1.tft_cs,    bus0.tft_cs};
    wire [1:0] sclkV = {bus1.tft_sclk,  bus0.tft_sclk};
    wire [1:0] mosiV = {bus1.tft_mosi,  bus0.tft_mosi};
    wire [1:0] dcV   = {bus1.tft_dc,    bus0.tft_dc};

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t mkExp(input logic [7:0] data, input logic dc, input int busyLen,
                                   input int csLowLen, input int gapBefore, input int csHighBefore,
                                   input bit aborted, input int abortRises);
        exp_t e;
        e.data         = data;
        e.dc           = dc;
        e.busyLen      = busyLen;
        e.csLowLen     = csLowLen;
        e.gapBefore    = gapBefore;
        e.csHighBefore = csHighBefore;
        e.aborted      = aborted;
        e.abortRises   = abortRises;
        return e;
    endfunction

    task automatic applyStimulus(input int k, input logic en, input logic dc, input logic [7:0] data);
        if (k == 0) begin
            bus0.send_en   = en;
            bus0.send_dc   = dc;
            bus0.send_data = data;
        end else begin
            bus1.send_en   = en;
            bus1.send_dc   = dc;
            bus1.send_data = data;
        end
    endtask

    task automatic waitIdle(input int k);
        int n;
        bit b;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            b = (k == 0) ? bus0.send_busy : bus1.send_busy;
            n++;
        end while (b && n < 300);
        checkOutput("waitIdle_timeout", int'(b), 0);
    endtask

    exp_t       cur[2];
    bit         haveCur[2];
    bit         prevBusy[2];
    bit         prevSclk[2];
    bit         prevMosi[2];
    int         busyLen[2];
    int         csLowLen[2];
    int         rises[2];
    int         runLen[2];
    int         timingErr[2];
    int         idleLen[2];
    int         csHighLen[2];
    logic [7:0] shiftIn[2];
    bit         dcAtStart[2];

    // Monitor: decode each byte from the pins and score it against the queue when busy drops
    always @(negedge clk) begin
        bit b, c, s, m, d;
        int div, pending;
        for (int k = 0; k < 2; k++) begin
            b   = busyV[k];
            c   = csV[k];
            s   = sclkV[k];
            m   = mosiV[k];
            d   = dcV[k];
            div = (k == 0) ? DIV0 : DIV1;

            if (b && !prevBusy[k]) begin
                pending = (k == 0) ? q0.size() : q1.size();
                checkOutput("accept_expected", int'(pending > 0), 1);
                if (pending > 0) begin
                    if (k == 0) cur[k] = q0.pop_front();
                    else        cur[k] = q1.pop_front();
                    haveCur[k] = 1'b1;
                    if (cur[k].gapBefore >= 0) begin
                        checkOutput("busy_low_gap", idleLen[k], cur[k].gapBefore);
                        checkOutput("cs_high_gap", csHighLen[k], cur[k].csHighBefore);
                    end
                end else begin
                    haveCur[k] = 1'b0;
                end
                busyLen[k]   = 1;
                csLowLen[k]  = c ? 0 : 1;
                rises[k]     = 0;
                shiftIn[k]   = 8'h00;
                dcAtStart[k] = d;
                timingErr[k] = 0;
                runLen[k]    = 1;
            end else if (b) begin
                busyLen[k]++;
                if (!c) csLowLen[k]++;
                if (s != prevSclk[k]) begin
                    if (runLen[k] != div) timingErr[k]++;
                    runLen[k] = 1;
                    if (s) begin
                        rises[k]++;
                        shiftIn[k] = {shiftIn[k][6:0], m};
                    end
                end else begin
                    runLen[k]++;
                end
                if (m != prevMosi[k] && !(prevSclk[k] && !s)) timingErr[k]++;
                if (d != dcAtStart[k]) timingErr[k]++;
            end else if (prevBusy[k] && haveCur[k]) begin
                if (cur[k].aborted) begin
                    checkOutput("abort_rises", rises[k], cur[k].abortRises);
                    checkOutput("abort_cs", int'(c), 1);
                    checkOutput("abort_sclk", int'(s), 0);
                    checkOutput("abort_mosi", int'(m), 0);
                    checkOutput("abort_dc", int'(d), 0);
                end else begin
                    checkOutput("byte_data", int'(shiftIn[k]), int'(cur[k].data));
                    checkOutput("byte_dc", int'(dcAtStart[k]), int'(cur[k].dc));
                    checkOutput("sclk_rises", rises[k], 8);
                    checkOutput("busy_len", busyLen[k], cur[k].busyLen);
                    checkOutput("cs_low_len", csLowLen[k], cur[k].csLowLen);
                    checkOutput("phase_timing_errors", timingErr[k], 0);
                end
                haveCur[k] = 1'b0;
            end

            if (!b) idleLen[k]++;
            else    idleLen[k] = 0;
            if (c)  csHighLen[k]++;
            else    csHighLen[k] = 0;
            prevBusy[k] = b;
            prevSclk[k] = s;
            prevMosi[k] = m;
        end
    end

    // Directed stimulus sequence
    initial begin
        int riseCount;
        int n;
        bit prevS;

        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy0", bus0.send_busy, 0);
        checkOutput("rst_cs0",   bus0.tft_cs,    1);
        checkOutput("rst_sclk0", bus0.tft_sclk,  0);
        checkOutput("rst_mosi0", bus0.tft_mosi,  0);
        checkOutput("rst_dc0",   bus0.tft_dc,    0);
        checkOutput("rst_busy1", bus1.send_busy, 0);
        checkOutput("rst_cs1",   bus1.tft_cs,    1);
        checkOutput("rst_sclk1", bus1.tft_sclk,  0);

        // Single-cycle request, command byte 0x29, released together with reset
        rst = 1'b0;
        q0.push_back(mkExp(8'h29, 1'b0, 38, 36, -1, 0, 1'b0, 0));
        applyStimulus(0, 1'b1, 1'b0, 8'h29);
        @(posedge clk);
        #1;
        checkOutput("first_accept_after_rst", bus0.send_busy, 1);
        applyStimulus(0, 1'b0, 1'b0, 8'h29);
        waitIdle(0);

        // send_en held high: back-to-back data bytes 0xA5 then 0x3C
        q0.push_back(mkExp(8'hA5, 1'b1, 38, 36, -1, 0, 1'b0, 0));
        q0.push_back(mkExp(8'h3C, 1'b1, 38, 36, 1, 3, 1'b0, 0));
        applyStimulus(0, 1'b1, 1'b1, 8'hA5);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 1'b1, 8'h3C);
        waitIdle(0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b1, 8'h3C);
        waitIdle(0);

        // Inputs changed while busy must be ignored
        q0.push_back(mkExp(8'h5A, 1'b0, 38, 36, -1, 0, 1'b0, 0));
        applyStimulus(0, 1'b1, 1'b0, 8'h5A);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 1'b1, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b1, 8'hFF);
        waitIdle(0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("dc_hold_idle", bus0.tft_dc, 0);
        checkOutput("idle_no_accept", bus0.send_busy, 0);

        // Reset at the 4th SCLK rise aborts the byte; a new request then completes
        q0.push_back(mkExp(8'hC3, 1'b1, 0, 0, -1, 0, 1'b1, 4));
        applyStimulus(0, 1'b1, 1'b1, 8'hC3);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b1, 8'hC3);
        riseCount = 0;
        n = 0;
        prevS = bus0.tft_sclk;
        while (riseCount < 4 && n < 200) begin
            @(posedge clk);
            #1;
            if (bus0.tft_sclk && !prevS) riseCount++;
            prevS = bus0.tft_sclk;
            n++;
        end
        checkOutput("abort_reached_rise4", riseCount, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy_now", bus0.send_busy, 0);
        q0.push_back(mkExp(8'h96, 1'b0, 38, 36, -1, 0, 1'b0, 0));
        applyStimulus(0, 1'b1, 1'b0, 8'h96);
        @(posedge clk);
        #1;
        checkOutput("accept_after_abort", bus0.send_busy, 1);
        applyStimulus(0, 1'b0, 1'b0, 8'h96);
        waitIdle(0);

        // Fastest timing instance: 0x80
        q1.push_back(mkExp(8'h80, 1'b0, 19, 18, -1, 0, 1'b0, 0));
        applyStimulus(1, 1'b1, 1'b0, 8'h80);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 1'b0, 8'h80);
        waitIdle(1);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("q0_drained", q0.size(), 0);
        checkOutput("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
